// File: rtl/memory_cycle.sv
// MEM stage: EX/MEM pipeline register, data-memory handshake FSM, store lane
// steering and load byte alignment. A slow memory freezes the pipe through StallM.
module memory_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        JtypeE,
    input  logic        MemReadE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [5:0]  ALUSelectE,
    input  logic [4:0]  WriteAddressE,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        RegWriteM,
    output logic        JtypeM,
    output logic        MemReadM,
    output logic [31:0] DataMemOutM,
    output logic [31:0] ALUOutM,
    output logic [5:0]  ALUSelectM,
    output logic [4:0]  WriteAddressM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        RegWrite2FU,
    output logic [4:0]  WriteAddress2FU,
    output logic [31:0] ALUOut2FU
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic        rw;
        logic        j;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [5:0]  sel;
        logic [4:0]  wa;
    } exmem_t;

    state_t      state_q, state_d;
    exmem_t      exmem_q, exmem_d;
    logic [31:0] hold_q;
    logic        hold_en;
    logic        access, mem_op;
    logic [1:0]  off;
    logic [31:0] rd_src;

    assign exmem_d = '{rw: RegWriteE, j: JtypeE, mr: MemReadE, mw: MemWriteE,
                       alu: ALUOutE, wd: WriteDataE, sel: ALUSelectE, wa: WriteAddressE};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            exmem_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!StallM) exmem_q <= exmem_d;
            if (hold_en) hold_q <= mem_rdata;
        end
    end

    assign off    = exmem_q.alu[1:0];
    assign access = exmem_q.mr | exmem_q.mw;

    // funct3[1:0]: 00 byte, 01 half, 1x word (BU/HU share the low bits with B/H)
    always_comb begin
        MisalignM = 1'b0;
        if (access) begin
            unique case (exmem_q.sel[1:0])
                2'b00:   MisalignM = 1'b0;
                2'b01:   MisalignM = off[0];
                default: MisalignM = (off != 2'b00);
            endcase
        end
    end

    assign mem_op = access & ~MisalignM;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        StallM  = 1'b0;
        hold_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_req = mem_op;
                if (mem_op && !mem_ready) begin
                    StallM  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                if (mem_ready) begin
                    hold_en = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields depend only on the latched op, so they hold across WAIT.
    always_comb begin
        mem_addr  = {exmem_q.alu[31:2], 2'b00};
        mem_we    = exmem_q.mw;
        mem_be    = 4'b1111;
        mem_wdata = exmem_q.wd;
        if (exmem_q.mw) begin
            unique case (exmem_q.sel[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << off;
                    mem_wdata = {4{exmem_q.wd[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << {off[1], 1'b0};
                    mem_wdata = {2{exmem_q.wd[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = exmem_q.wd;
                end
            endcase
        end
    end

    assign rd_src      = (state_q == DONE) ? hold_q : mem_rdata;
    assign DataMemOutM = (exmem_q.mr && !MisalignM) ? (rd_src >> {off, 3'b000}) : 32'd0;

    assign RegWriteM       = exmem_q.rw & ~StallM & ~MisalignM;
    assign JtypeM          = exmem_q.j;
    assign MemReadM        = exmem_q.mr;
    assign ALUOutM         = exmem_q.alu;
    assign ALUSelectM      = exmem_q.sel;
    assign WriteAddressM   = exmem_q.wa;
    assign RegWrite2FU     = RegWriteM;
    assign WriteAddress2FU = WriteAddressM;
    assign ALUOut2FU       = ALUOutM;
endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed ops with literal checks, plus a transaction-level
// model compared against every output on every cycle after reset.
module tb_memory_cycle;
    logic        clk, rst;
    logic        RegWriteE, JtypeE, MemReadE, MemWriteE;
    logic [31:0] ALUOutE, WriteDataE;
    logic [5:0]  ALUSelectE;
    logic [4:0]  WriteAddressE;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        RegWriteM, JtypeM, MemReadM, StallM, MisalignM, RegWrite2FU;
    logic [31:0] DataMemOutM, ALUOutM, ALUOut2FU;
    logic [5:0]  ALUSelectM;
    logic [4:0]  WriteAddressM, WriteAddress2FU;

    int errors = 0;
    int checks = 0;

    memory_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .JtypeE(JtypeE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .ALUSelectE(ALUSelectE),
        .WriteAddressE(WriteAddressE),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .RegWriteM(RegWriteM), .JtypeM(JtypeM), .MemReadM(MemReadM),
        .DataMemOutM(DataMemOutM), .ALUOutM(ALUOutM), .ALUSelectM(ALUSelectM),
        .WriteAddressM(WriteAddressM), .StallM(StallM), .MisalignM(MisalignM),
        .RegWrite2FU(RegWrite2FU), .WriteAddress2FU(WriteAddress2FU), .ALUOut2FU(ALUOut2FU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the latched op plus whether its access is outstanding or finished.
    logic        mvalid = 1'b0;
    logic        m_rw, m_j, m_mr, m_mw, m_wait, m_done;
    logic [31:0] m_alu, m_wd, m_held;
    logic [5:0]  m_sel;
    logic [4:0]  m_wa;

    function automatic int m_size();
        case (m_sel[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_mis();
        int n = m_size();
        int o = int'(m_alu[1:0]);
        return (m_mr || m_mw) && ((n == 2 && (o % 2) != 0) || (n == 4 && o != 0));
    endfunction

    function automatic logic m_memop();
        return (m_mr || m_mw) && !m_mis();
    endfunction

    function automatic logic m_stall();
        return m_wait || (m_memop() && !m_done && !mem_ready);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {m_rw, m_j, m_mr, m_mw, m_wait, m_done} = '0;
            m_alu = 0; m_wd = 0; m_held = 0; m_sel = 0; m_wa = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            logic st;
            st = m_stall();
            if (m_done) m_done = 1'b0;
            else if (m_wait) begin
                if (mem_ready) begin
                    m_held = mem_rdata;
                    m_wait = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_memop() && !mem_ready) m_wait = 1'b1;
            if (!st) begin
                m_rw = RegWriteE; m_j = JtypeE; m_mr = MemReadE; m_mw = MemWriteE;
                m_alu = ALUOutE; m_wd = WriteDataE; m_sel = ALUSelectE; m_wa = WriteAddressE;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            int n, o;
            logic st, mis, req;
            logic [31:0] be, lo, wd;
            n   = m_size();
            o   = int'(m_alu[1:0]);
            mis = m_mis();
            st  = m_stall();
            req = m_memop() && !m_done;
            chk("StallM", 32'(StallM), 32'(st));
            chk("mem_req", 32'(mem_req), 32'(req));
            chk("MisalignM", 32'(MisalignM), 32'(mis));
            chk("RegWriteM", 32'(RegWriteM), 32'(m_rw && !st && !mis));
            chk("ALUOutM", ALUOutM, m_alu);
            chk("ALUSelectM", 32'(ALUSelectM), 32'(m_sel));
            chk("WriteAddressM", 32'(WriteAddressM), 32'(m_wa));
            chk("JtypeM", 32'(JtypeM), 32'(m_j));
            chk("MemReadM", 32'(MemReadM), 32'(m_mr));
            chk("RegWrite2FU", 32'(RegWrite2FU), 32'(m_rw && !st && !mis));
            chk("WriteAddress2FU", 32'(WriteAddress2FU), 32'(m_wa));
            chk("ALUOut2FU", ALUOut2FU, m_alu);
            if (req) begin
                chk("mem_addr", mem_addr, m_alu - 32'(o));
                chk("mem_we", 32'(mem_we), 32'(m_mw));
                if (m_mw) begin
                    lo = (n == 4) ? m_wd : (m_wd & ((32'd1 << (8 * n)) - 1));
                    wd = (n == 1) ? lo * 32'h0101_0101 : (n == 2) ? lo * 32'h0001_0001 : lo;
                    be = ((32'd1 << n) - 1) << ((n == 1) ? o : (n == 2) ? (o / 2) * 2 : 0);
                end else begin
                    wd = mem_wdata;
                    be = 32'hF;
                end
                chk("mem_be", 32'(mem_be), be);
                if (m_mw) chk("mem_wdata", mem_wdata, wd);
            end
            if (m_mr && !mis) begin
                if (!st) chk("DataMemOutM", DataMemOutM, (m_done ? m_held : mem_rdata) >> (8 * o));
            end else chk("DataMemOutM_idle", DataMemOutM, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic rw, input logic j, input logic mr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [5:0] sel, input logic [4:0] wa);
        RegWriteE = rw; JtypeE = j; MemReadE = mr; MemWriteE = mw;
        ALUOutE = alu; WriteDataE = wd; ALUSelectE = sel; WriteAddressE = wa;
    endtask

    task automatic nop();
        set_e(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
        nop();
        step(); step();
        @(negedge clk);
        chk("rst_StallM", 32'(StallM), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ALUOutM", ALUOutM, 0);
        chk("rst_RegWriteM", 32'(RegWriteM), 0);
        rst = 1'b0;

        // ADD
        set_e(1, 0, 0, 0, 32'h10, 0, 6'd0, 5'd5);
        step(); nop();
        @(negedge clk);
        chk("add_ALUOutM", ALUOutM, 32'h10);
        chk("add_RegWriteM", 32'(RegWriteM), 1);
        chk("add_WAM", 32'(WriteAddressM), 5);
        chk("add_StallM", 32'(StallM), 0);
        chk("add_mem_req", 32'(mem_req), 0);

        // SB, ready same cycle
        set_e(0, 0, 0, 1, 32'h103, 32'hAB, 6'd0, 5'd0);
        step(); nop(); mem_ready = 1'b1;
        @(negedge clk);
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_be", 32'(mem_be), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_we", 32'(mem_we), 1);
        chk("sb_StallM", 32'(StallM), 0);

        // SH upper half, then SW
        set_e(0, 0, 0, 1, 32'h102, 32'h5678_1234, 6'd1, 5'd0);
        step(); nop();
        @(negedge clk);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        set_e(0, 0, 0, 1, 32'h204, 32'hCAFE_F00D, 6'd2, 5'd0);
        step(); nop();
        @(negedge clk);
        chk("sw_be", 32'(mem_be), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);

        // LW with three wait cycles; a younger ADD waits at the E inputs
        set_e(1, 0, 1, 0, 32'h200, 0, 6'd2, 5'd7);
        step(); mem_ready = 1'b0;
        set_e(1, 0, 0, 0, 32'h55, 0, 6'd0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            chk("lw_StallM", 32'(StallM), 1);
            chk("lw_RegWriteM", 32'(RegWriteM), 0);
            chk("lw_ALUOutM_hold", ALUOutM, 32'h200);
            if (i != 3) step();
        end
        step(); mem_ready = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        chk("lw_done_data", DataMemOutM, 32'hDEAD_BEEF);
        chk("lw_done_RegWriteM", 32'(RegWriteM), 1);
        chk("lw_done_StallM", 32'(StallM), 0);
        chk("lw_done_req", 32'(mem_req), 0);
        step(); nop();
        @(negedge clk);
        chk("after_lw_ALUOutM", ALUOutM, 32'h55);

        // LH and LBU alignment
        set_e(1, 0, 1, 0, 32'h102, 0, 6'd1, 5'd4);
        step(); nop(); mem_ready = 1'b1; mem_rdata = 32'h8001_0000;
        @(negedge clk);
        chk("lh_data", DataMemOutM, 32'h0000_8001);
        chk("lh_RegWriteM", 32'(RegWriteM), 1);
        set_e(1, 0, 1, 0, 32'h103, 0, 6'd4, 5'd4);
        step(); nop(); mem_rdata = 32'hAB00_0000;
        @(negedge clk);
        chk("lbu_data", DataMemOutM, 32'h0000_00AB);

        // Misaligned LW; mem_ready is ignored
        set_e(1, 0, 1, 0, 32'h101, 0, 6'd2, 5'd6);
        step(); nop();
        @(negedge clk);
        chk("mis_MisalignM", 32'(MisalignM), 1);
        chk("mis_mem_req", 32'(mem_req), 0);
        chk("mis_RegWriteM", 32'(RegWriteM), 0);
        chk("mis_StallM", 32'(StallM), 0);

        // JAL-like op passes in one cycle
        set_e(1, 1, 0, 0, 32'h44, 0, 6'd0, 5'd1);
        step(); nop(); mem_ready = 1'b0;
        @(negedge clk);
        chk("j_JtypeM", 32'(JtypeM), 1);
        chk("j_RegWriteM", 32'(RegWriteM), 1);

        // Reset while in WAIT
        set_e(1, 0, 1, 0, 32'h300, 0, 6'd2, 5'd3);
        step(); nop(); mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rw_StallM", 32'(StallM), 1);
        step();
        @(negedge clk);
        chk("rw_wait_req", 32'(mem_req), 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("rw_mem_req", 32'(mem_req), 0);
        chk("rw_StallM", 32'(StallM), 0);
        chk("rw_ALUOutM", ALUOutM, 0);
        chk("rw_WAM", 32'(WriteAddressM), 0);
        chk("rw_RegWriteM", 32'(RegWriteM), 0);
        chk("rw_DataMemOutM", DataMemOutM, 0);
        chk("rw_MemReadM", 32'(MemReadM), 0);

        step(); step();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 RegWriteE, JtypeE, MemReadE, MemWriteE  in  1 each  execute-stage control.
REQ-005 ALUOutE  in  32  ALU result or effective address.
REQ-006 WriteDataE  in  32  store data (rs2).
REQ-007 ALUSelectE  in  6  op select; [2:0] = funct3 for loads/stores (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 WriteAddressE  in  5  destination register.
REQ-009 mem_req, mem_we  out  1 each  data-memory request and write enable.
REQ-010 mem_addr  out  32  word-aligned address {ALUOut[31:2],2'b00}.
REQ-011 mem_wdata  out  32; mem_be  out  4  lane-replicated store data and byte enables.
REQ-012 mem_rdata  in  32; mem_ready  in  1  read data and completion strobe.
REQ-013 RegWriteM, JtypeM, MemReadM  out  1 each; DataMemOutM, ALUOutM  out  32; ALUSelectM  out  6; WriteAddressM  out  5  (to writeback).
REQ-014 StallM  out  1  freeze request to hazard unit; MisalignM  out  1  misaligned-access flag.
REQ-015 RegWrite2FU  out  1; WriteAddress2FU  out  5; ALUOut2FU  out  32  forwarding-unit taps.

Function
REQ-016 The EX/MEM register SHALL capture all E inputs on a clk edge when StallM=0, and SHALL hold when StallM=1.
REQ-017 ALUOutM, ALUSelectM, WriteAddressM, JtypeM, MemReadM SHALL be driven directly from the EX/MEM register.
REQ-018 A latched op is a memory op when MemRead or MemWrite is set and MisalignM=0.
REQ-019 MisalignM SHALL be 1 for a H/HU access with addr[0]=1 or a W access with addr[1:0]!=0; no mem_req is issued, and RegWriteM SHALL be 0.
REQ-020 FSM states: IDLE, WAIT, DONE.
REQ-021 IDLE, memory op latched: mem_req=1; mem_ready=1 -> op completes with StallM=0, stay IDLE; mem_ready=0 -> StallM=1, go WAIT.
REQ-022 WAIT: mem_req=1 and StallM=1; mem_ready=1 -> capture mem_rdata into a holding register and go DONE.
REQ-023 DONE: mem_req=0, StallM=0, DataMemOutM sourced from the holding register; the EX/MEM register advances and the FSM returns to IDLE.
REQ-024 Non-memory ops SHALL pass in one cycle, with StallM=0 and mem_req=0.
REQ-025 mem_addr, mem_we, mem_wdata and mem_be SHALL stay constant while mem_req=1.
REQ-026 Store byte lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{WriteData[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{WriteData[15:0]}}.
  - SW: be=4'b1111, wdata=WriteData.
REQ-027 Loads:
  - mem_we=0 and be=4'b1111.
  - DataMemOutM = selected word >> (8*addr[1:0]), zero-filled.
  - Sign/zero extension is left to writeback.
REQ-028 RegWriteM SHALL equal the latched RegWrite AND NOT StallM AND NOT MisalignM.
REQ-029 RegWrite2FU SHALL equal RegWriteM; WriteAddress2FU SHALL equal WriteAddressM; ALUOut2FU SHALL equal ALUOutM.
REQ-030 WAIT SHALL be held indefinitely until mem_ready; there is no timeout.
REQ-031 mem_ready outside IDLE-with-memory-op or WAIT SHALL be ignored.

Reset
REQ-032 With rst=1 at a clk edge, the EX/MEM register, the holding register and all M outputs SHALL be 0, and the FSM SHALL go to IDLE.
REQ-033 On that edge StallM, mem_req and MisalignM SHALL be 0.
REQ-034 Reset during WAIT SHALL abandon the access: mem_req=0 in the next cycle, with no register write.

Verification
REQ-035 ADD, ALUOutE=0x10, WriteAddressE=5, RegWriteE=1 -> next cycle: ALUOutM=0x10, RegWriteM=1, WriteAddressM=5, StallM=0, mem_req=0.
REQ-036 SB, addr=0x103, WriteDataE=0xAB -> mem_addr=0x100, be=4'b1000, wdata=0xABABABAB, mem_we=1; mem_ready same cycle -> StallM=0.
REQ-037 LW, addr=0x200, mem_ready low 3 cycles then high with rdata=0xDEADBEEF:
  - StallM=1 for 4 cycles, RegWriteM=0 throughout.
  - DONE: DataMemOutM=0xDEADBEEF, RegWriteM=1.
REQ-038 LH, addr=0x102, rdata=0x8001_0000 -> DataMemOutM=0x0000_8001; LW at addr=0x101 -> MisalignM=1, mem_req=0, RegWriteM=0.
REQ-039 rst asserted in WAIT -> next cycle: IDLE, mem_req=0, StallM=0, all M outputs 0.
